float_result_queue: RTL and testbench
=====================================

# float_result_queue

Parametrised result buffer between the `float_alu` output port and its consumer. Captures `{result, flags, tag}` beats on a valid/ready handshake into a DEPTH-entry circular FIFO so the ALU never stalls on a slow consumer. Accumulates IEEE-754 exception flags into a sticky status register and raises a maskable exception interrupt. Generalises the single-beat `valid_out`/`ready_in` contract to N in flight, with per-operation tags.

## Interface
- `DATA_W`, 32 — result width (32 single; 64 reserved for double).
- `FLAG_W`, 5 — flag width. Bit order: [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact.
- `DEPTH`, 4 — entries; power of two, ≥2.
- `TAG_W`, 3 — operation tag width.
- `clk` in 1 — sole clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — ALU beat valid.
- `in_ready` out 1 — queue can accept a beat.
- `in_result` in DATA_W — ALU result.
- `in_flags` in FLAG_W — ALU flags for this result.
- `in_tag` in TAG_W — tag issued with the operation.
- `out_valid` out 1 — head entry valid.
- `out_ready` in 1 — consumer accepts head.
- `out_result` out DATA_W, `out_flags` out FLAG_W, `out_tag` out TAG_W — head entry fields.
- `count` out $clog2(DEPTH)+1 — current occupancy.
- `sticky_flags` out FLAG_W — OR of all flags pushed since last clear.
- `sticky_clr` in 1 — clear sticky flags.
- `flag_mask` in FLAG_W — interrupt enable per flag bit.
- `exc_irq` out 1 — registered, |(sticky_flags & flag_mask).

## Operation
- Push when `in_valid && in_ready`: write entry at `wr_ptr`, `wr_ptr` increments mod DEPTH.
- Pop when `out_valid && out_ready`: `rd_ptr` increments mod DEPTH.
- `count` is +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- `in_ready` = (`count` != DEPTH), from registered state. Full with pop in the same cycle still refuses the push (no pass-through).
- `out_valid` = (`count` != 0). Head fields are driven from `mem[rd_ptr]`; they are don't-care while `out_valid`=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided by `count`, not by pointer compare.
- Sticky update on push: `sticky_flags <= (sticky_clr ? 0 : sticky_flags) | in_flags`. The push wins over a same-cycle clear.
- `sticky_clr` without a push zeroes `sticky_flags`.
- `exc_irq` is recomputed each cycle from the next sticky value and `flag_mask`. It is level, not pulse.
- Entries are never reordered or dropped. Input held while `in_ready`=0 is not captured.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `count`=0, `sticky_flags`=0, `exc_irq`=0, pointers=0. Memory contents are not reset.
- `rst` asserted mid-operation discards all entries on the next edge. Any push or pop in that cycle is ignored.
- Latency push→`out_valid` is 1 cycle (beat pushed at edge N is at the head after edge N).
- Sticky/`exc_irq` become visible 1 cycle after the push carrying the flag.
- Throughput: one push and one pop per cycle when 0 < `count` < DEPTH.

## Configuration
- `FRQ_BYPASS_EN` defined: when `count`=0 and `in_valid`, the input fields drive the output combinationally.
  - `out_valid` = `in_valid`.
  - If `out_ready` is also high, the beat is consumed with no write; pointers and `count` are unchanged.
  - Sticky flags still update.
  - Latency becomes 0 cycles on an empty queue.
- Not defined: strict 1-cycle registered latency as above. No combinational path from `in_*` to `out_*`.

## Test plan
- Reset, then push {0x41B80000 (23.0), flags 0, tag 0} with `out_ready`=1.
  - Without bypass: `out_valid`=1 exactly one cycle later with the same fields; `count` returns 0; `sticky_flags`=0.
- With `out_ready`=0, push 4 beats (tags 0..3).
  - `count`=4, `in_ready`=0, and a 5th push is held.
  - Raising `out_ready` pops tags 0,1,2,3 in order. `in_ready` goes to 1 after the first pop.
- Push 0x3E99999A flags 5'b00001 with `flag_mask`=5'b00001.
  - `sticky_flags`=00001 and `exc_irq`=1 one cycle later.
  - Pulse `sticky_clr` → both 0 next cycle.
- Push 0x7F800000 flags 5'b00100 in the same cycle as `sticky_clr` with previous sticky 00001 → `sticky_flags`=00100 (push wins).
- At `count`=2, run simultaneous push and pop for 6 cycles.
  - `count` stays 2; pointers wrap past DEPTH−1; output order matches input tags.
- Assert `rst` with `count`=3.
  - Next cycle `count`=0, `out_valid`=0, `in_ready`=1, `sticky_flags`=0.
  - A push in the reset cycle is not retained.

Source files
------------

// File: rtl/float_result_queue_if.sv
// Handshake, status and control bundle between the float ALU, the result queue and its consumer.
// slave = queue side, master = ALU/consumer side.
interface float_result_queue_if #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [FLAG_W-1:0] in_flags;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [FLAG_W-1:0] out_flags;
    logic [TAG_W-1:0]  out_tag;

    logic [CNT_W-1:0]  count;
    logic [FLAG_W-1:0] sticky_flags;
    logic              sticky_clr;
    logic [FLAG_W-1:0] flag_mask;
    logic              exc_irq;

    modport slave (
        input  in_valid, in_result, in_flags, in_tag, out_ready, sticky_clr, flag_mask,
        output in_ready, out_valid, out_result, out_flags, out_tag, count, sticky_flags, exc_irq
    );

    modport master (
        output in_valid, in_result, in_flags, in_tag, out_ready, sticky_clr, flag_mask,
        input  in_ready, out_valid, out_result, out_flags, out_tag, count, sticky_flags, exc_irq
    );
endinterface

// File: rtl/float_result_queue.sv
// Circular result FIFO for float ALU beats with sticky IEEE-754 exception flags and maskable IRQ.
// Define FRQ_BYPASS_EN to let an empty queue forward the input beat combinationally.
module float_result_queue #(
    parameter int DATA_W = 32,
    parameter int FLAG_W = 5,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3
) (
    input logic                 clk,
    input logic                 rst,
    float_result_queue_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + FLAG_W + TAG_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FLAG_W-1:0]  sticky_q, sticky_d;
    logic               irq_q, irq_d;

    logic               full, empty, push, wr_en, pop;
    logic [FLAG_W-1:0]  sticky_base;
    logic [ENTRY_W-1:0] head;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    assign bus.in_ready     = !full;
    assign bus.count        = count_q;
    assign bus.sticky_flags = sticky_q;
    assign bus.exc_irq      = irq_q;

`ifdef FRQ_BYPASS_EN
    logic bypass;
    assign bypass        = empty && bus.in_valid;
    assign bus.out_valid = !empty || bypass;
    assign bus.out_result = bypass ? bus.in_result : head[ENTRY_W-1 -: DATA_W];
    assign bus.out_flags  = bypass ? bus.in_flags  : head[TAG_W +: FLAG_W];
    assign bus.out_tag    = bypass ? bus.in_tag    : head[TAG_W-1:0];
    // A forwarded beat taken by the consumer never occupies an entry.
    assign wr_en = push && !(bypass && bus.out_ready);
`else
    assign bus.out_valid  = !empty;
    assign bus.out_result = head[ENTRY_W-1 -: DATA_W];
    assign bus.out_flags  = head[TAG_W +: FLAG_W];
    assign bus.out_tag    = head[TAG_W-1:0];
    assign wr_en = push;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // A push in the same cycle as a clear still records its flags.
    always_comb begin
        sticky_base = bus.sticky_clr ? '0 : sticky_q;
        sticky_d    = push ? (sticky_base | bus.in_flags) : sticky_base;
        irq_d       = |(sticky_d & bus.flag_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_ptr_q] <= {bus.in_result, bus.in_flags, bus.in_tag};
    end
endmodule

// File: tb/tb_float_result_queue.sv
// Scoreboard bench for float_result_queue: directed test-plan sequences followed by random traffic.
module tb_float_result_queue;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 5;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 3;

    typedef struct {
        logic [DATA_W-1:0] r;
        logic [FLAG_W-1:0] f;
        logic [TAG_W-1:0]  t;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    beat_t             sb[$];
    beat_t             h;
    logic [FLAG_W-1:0] sticky_m = '0;
    logic [FLAG_W-1:0] nxt;
    logic              irq_m = 1'b0;
    logic              byp, acc;
    int                n;

    float_result_queue_if #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    float_result_queue #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a list of accepted beats; sticky is the OR of accepted flags.
    always @(negedge clk) begin
        n   = sb.size();
        byp = 1'b0;
`ifdef FRQ_BYPASS_EN
        byp = (n == 0) && bus.in_valid;
`endif
        chk("count", 64'(bus.count), 64'(n));
        chk("in_ready", 64'(bus.in_ready), 64'(n != DEPTH));
        chk("out_valid", 64'(bus.out_valid), 64'((n != 0) || byp));
        chk("sticky_flags", 64'(bus.sticky_flags), 64'(sticky_m));
        chk("exc_irq", 64'(bus.exc_irq), 64'(irq_m));
        if (rst) begin
            sb.delete();
            sticky_m = '0;
            irq_m    = 1'b0;
        end else begin
            acc = bus.in_valid && (n != DEPTH);
            if (n != 0) begin
                h = sb[0];
                chk("out_result", 64'(bus.out_result), 64'(h.r));
                chk("out_flags", 64'(bus.out_flags), 64'(h.f));
                chk("out_tag", 64'(bus.out_tag), 64'(h.t));
                if (bus.out_ready) void'(sb.pop_front());
            end else if (byp) begin
                chk("byp_result", 64'(bus.out_result), 64'(bus.in_result));
                chk("byp_tag", 64'(bus.out_tag), 64'(bus.in_tag));
            end
            if (acc && !(byp && bus.out_ready)) begin
                h.r = bus.in_result;
                h.f = bus.in_flags;
                h.t = bus.in_tag;
                sb.push_back(h);
            end
            nxt = bus.sticky_clr ? '0 : sticky_m;
            if (acc) nxt = nxt | bus.in_flags;
            sticky_m = nxt;
            irq_m    = |(nxt & bus.flag_mask);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] f, input logic [2:0] t);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_flags  = f;
        bus.in_tag    = t;
    endtask

    initial begin
        drive(1'b0, '0, '0, '0);
        bus.out_ready  = 1'b0;
        bus.sticky_clr = 1'b0;
        bus.flag_mask  = '0;
        step(2);
        rst = 1'b0;

        // Single beat of 23.0 with consumer ready
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h41B80000, 5'b0, 3'd0);
        step(1);
        drive(1'b0, '0, '0, '0);
        step(2);

        // Fill to DEPTH, hold a fifth beat, then drain in order
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3F800000 + 32'(i), 5'b0, 3'(i));
            step(1);
        end
        drive(1'b1, 32'h40A00000, 5'b0, 3'd4);
        step(3);
        bus.out_ready = 1'b1;
        step(1);
        drive(1'b0, '0, '0, '0);
        step(6);

        // Inexact flag raises the interrupt, then clear
        bus.flag_mask = 5'b00001;
        drive(1'b1, 32'h3E99999A, 5'b00001, 3'd5);
        step(1);
        drive(1'b0, '0, '0, '0);
        step(2);
        bus.sticky_clr = 1'b1;
        step(1);
        bus.sticky_clr = 1'b0;
        step(2);

        // Push wins over a same-cycle clear
        drive(1'b1, 32'h3E99999A, 5'b00001, 3'd6);
        step(1);
        drive(1'b1, 32'h7F800000, 5'b00100, 3'd7);
        bus.sticky_clr = 1'b1;
        step(1);
        bus.sticky_clr = 1'b0;
        drive(1'b0, '0, '0, '0);
        step(3);

        // Steady state at count 2 with simultaneous push/pop wrapping the pointers
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hC0000000 + 32'(i), 5'b0, 3'(i));
            step(1);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hC1000000 + 32'(i), 5'b0, 3'(i + 2));
            step(1);
        end
        drive(1'b0, '0, '0, '0);
        step(3);

        // Reset with three entries queued and a push in the reset cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h42000000 + 32'(i), 5'b00010, 3'(i));
            step(1);
        end
        rst = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 5'b10000, 3'd7);
        step(1);
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        step(2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0, 3'($urandom));
            bus.out_ready  = 1'($urandom_range(0, 2) != 0);
            bus.sticky_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) bus.flag_mask = 5'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step(1);
        end
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        bus.sticky_clr = 1'b0;
        bus.out_ready  = 1'b1;
        step(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
